// File: rtl/cntdiv_n.sv
`default_nettype none
// ============================================================================
// cntdiv_n : divides clk by N into a registered square-wave "seconds" clock.
// Rev 1.0 : initial release
// ============================================================================
module cntdiv_n #(
   parameter int unsigned N = 50_000_000
) (
   input  logic clk,
   input  logic reset,
   output logic clk_out
);

   localparam int CW = (N > 2) ? $clog2(N) : 1;
   localparam logic [CW-1:0] C_LAST = CW'(N - 1);
   localparam logic [CW-1:0] C_HALF = CW'(N / 2 - 1);

   generate
      if (N < 2) begin : g_bad_n
         $error("cntdiv_n: N must be at least 2");
      end
   endgenerate

   logic [CW-1:0] cnt;

   // clk_out is set halfway through the period and cleared on the wrap,
   // so it comes straight from a flop and never glitches.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt     <= '0;
         clk_out <= 1'b0;
      end else begin
         cnt <= (cnt == C_LAST) ? '0 : cnt + CW'(1);
         if (cnt == C_HALF)
            clk_out <= 1'b1;
         else if (cnt == C_LAST)
            clk_out <= 1'b0;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_cntdiv_n.sv
`default_nettype none
// ============================================================================
// tb_cntdiv_n : scoreboard bench for cntdiv_n at N = 8, 5, 2 and the default.
// Rev 1.0 : initial release
// ============================================================================
module tb_cntdiv_n;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic clk_out8, clk_out5, clk_out2, clk_out_def;

   int checks = 0;
   int errors = 0;
   int k = 0;               // clk edges since reset release
   logic [3:0] sb[$];

   always #5 clk = ~clk;

   cntdiv_n #(.N(8)) dut8   (.clk(clk), .reset(reset), .clk_out(clk_out8));
   cntdiv_n #(.N(5)) dut5   (.clk(clk), .reset(reset), .clk_out(clk_out5));
   cntdiv_n #(.N(2)) dut2   (.clk(clk), .reset(reset), .clk_out(clk_out2));
   cntdiv_n          dutdef (.clk(clk), .reset(reset), .clk_out(clk_out_def));

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s got %0d want %0d at k=%0d t=%0t", tag, obs, exp, k, $time);
      end
   endtask

   // High once the phase within the period reaches N/2.
   function automatic logic model(input int unsigned n, input int kk);
      return (int'(kk % n) >= int'(n / 2));
   endfunction

   logic prev8;
   int rises8;

   task automatic step();
      logic [3:0] e;
      @(posedge clk);
      if (!reset) k++;
      sb.push_back({model(8, k), model(5, k), model(2, k), model(50_000_000, k)});
      #1;
      e = sb.pop_front();
      check_eq("n8",   {31'd0, clk_out8},    {31'd0, e[3]});
      check_eq("n5",   {31'd0, clk_out5},    {31'd0, e[2]});
      check_eq("n2",   {31'd0, clk_out2},    {31'd0, e[1]});
      check_eq("ndef", {31'd0, clk_out_def}, {31'd0, e[0]});
      check_eq("n8_cnt_range", {31'd0, (dut8.cnt <= 3'd7)}, 32'd1);
      check_eq("n8_noX", {31'd0, $isunknown(clk_out8)}, 32'd0);
      if (clk_out8 && !prev8) rises8++;
      prev8 = clk_out8;
   endtask

   initial begin
      // held in reset across several edges
      #1;
      check_eq("reset_async_init", {28'd0, clk_out8, clk_out5, clk_out2, clk_out_def}, 32'd0);
      repeat (3) step();

      @(negedge clk);
      reset = 1'b0;
      k = 0;
      prev8 = 1'b0;
      rises8 = 0;
      repeat (288) step();
      check_eq("n8_rises_288", rises8, 32'd36);

      // assert reset mid-period while the N=8 output is high
      repeat (6) step();
      check_eq("n8_high_before_reset", {31'd0, clk_out8}, 32'd1);
      #2;
      reset = 1'b1;
      #1;
      check_eq("reset_async_mid", {28'd0, clk_out8, clk_out5, clk_out2, clk_out_def}, 32'd0);
      k = 0;
      repeat (2) step();

      @(negedge clk);
      reset = 1'b0;
      k = 0;
      prev8 = 1'b0;
      rises8 = 0;
      repeat (40) step();
      check_eq("n8_rises_after_reset", rises8, 32'd5);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout");
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire
